// File: rtl/k12a_alu_seq.sv
// rtl/k12a_alu_seq.sv - sequencer driving an external 8-bit ALU for ASR/LSL/MUL commands
// Optional multiply support is enabled with `define K12A_ALU_SEQ_MUL_EN.
package k12a_alu_seq_pkg;
  typedef enum logic {ALU_OPERAND_SEL_A = 1'b0, ALU_OPERAND_SEL_B = 1'b1} alu_operand_sel_t;
endpackage

module k12a_alu_seq
  import k12a_alu_seq_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       cmd_op,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [7:0]       result,
  output logic             alu_load,
  output alu_operand_sel_t alu_operand_sel,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [15:0]      alu_inst,
  input  logic [7:0]       data_bus
);

  localparam logic [2:0] OP_ADD = 3'd4;
  localparam logic [2:0] OP_ASR = 3'd6;

`ifdef K12A_ALU_SEQ_MUL_EN
  typedef enum logic [2:0] {IDLE, ASR, LSL, MUL_ADD, MUL_DBL, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, ASR, LSL, DONE} state_t;
`endif

  state_t     state, state_next;
  logic [1:0] op_q;
  logic [7:0] acc, mc, mp;
  logic [3:0] cnt;
  logic [7:0] result_q;
  logic [2:0] alu_op;
  logic       reserved;
  logic [7:0] result_final;

`ifdef K12A_ALU_SEQ_MUL_EN
  assign reserved = (op_q == 2'b11);
`else
  assign reserved = (op_q == 2'b11) || (op_q == 2'b01);
`endif

  assign result_final    = reserved ? 8'h00 : acc;
  assign busy            = (state != IDLE);
  assign done            = (state == DONE);
  assign err             = done && reserved;
  assign result          = done ? result_final : result_q;
  assign alu_operand_sel = ALU_OPERAND_SEL_B;
  assign alu_inst        = {5'b0, alu_op, 8'b0};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Zero-count shifts and reserved ops spend their single busy cycle in ASR with cnt=0, idling the ALU.
  always_comb begin
    state_next = state;
    alu_load   = 1'b0;
    alu_a      = 8'h00;
    alu_b      = 8'h00;
    alu_op     = 3'd0;
    case (state)
      IDLE: begin
        if (start) begin
          case (cmd_op)
            2'b10:   state_next = LSL;
`ifdef K12A_ALU_SEQ_MUL_EN
            2'b01:   state_next = MUL_ADD;
`endif
            default: state_next = ASR;
          endcase
        end
      end
      ASR: begin
        if (cnt != 4'd0) begin
          alu_load = 1'b1;
          alu_a    = acc;
          alu_op   = OP_ASR;
        end
        if (cnt <= 4'd1) state_next = DONE;
      end
      LSL: begin
        if (cnt != 4'd0) begin
          alu_load = 1'b1;
          alu_a    = acc;
          alu_b    = acc;
          alu_op   = OP_ADD;
        end
        if (cnt <= 4'd1) state_next = DONE;
      end
`ifdef K12A_ALU_SEQ_MUL_EN
      MUL_ADD: begin
        alu_load   = 1'b1;
        alu_a      = acc;
        alu_b      = mc;
        alu_op     = OP_ADD;
        state_next = MUL_DBL;
      end
      MUL_DBL: begin
        alu_load   = 1'b1;
        alu_a      = mc;
        alu_b      = mc;
        alu_op     = OP_ADD;
        state_next = (cnt == 4'd1) ? DONE : MUL_ADD;
      end
`endif
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_q     <= 2'b00;
      acc      <= 8'h00;
      mc       <= 8'h00;
      mp       <= 8'h00;
      cnt      <= 4'd0;
      result_q <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q <= cmd_op;
            mc   <= cmd_a;
            mp   <= cmd_b;
            case (cmd_op)
              2'b00, 2'b10: begin
                acc <= cmd_a;
                cnt <= {1'b0, cmd_b[2:0]};
              end
`ifdef K12A_ALU_SEQ_MUL_EN
              2'b01: begin
                acc <= 8'h00;
                cnt <= 4'd8;
              end
`endif
              default: begin
                acc <= 8'h00;
                cnt <= 4'd0;
              end
            endcase
          end
        end
        ASR, LSL: begin
          if (cnt != 4'd0) begin
            acc <= data_bus;
            cnt <= cnt - 4'd1;
          end
        end
`ifdef K12A_ALU_SEQ_MUL_EN
        MUL_ADD: begin
          if (mp[0]) acc <= data_bus;
        end
        MUL_DBL: begin
          mc  <= data_bus;
          mp  <= {1'b0, mp[7:1]};
          cnt <= cnt - 4'd1;
        end
`endif
        DONE:    result_q <= result_final;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_k12a_alu_seq.sv
// tb/tb_k12a_alu_seq.sv - self-checking bench for k12a_alu_seq with an external ALU model
// Honours `define K12A_ALU_SEQ_MUL_EN the same way as the design.
module tb_k12a_alu_seq;
  import k12a_alu_seq_pkg::*;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             start = 1'b0;
  logic [1:0]       cmd_op = 2'b00;
  logic [7:0]       cmd_a = 8'h00;
  logic [7:0]       cmd_b = 8'h00;
  logic             busy, done, err, alu_load;
  logic [7:0]       result, alu_a, alu_b, data_bus;
  alu_operand_sel_t alu_operand_sel;
  logic [15:0]      alu_inst;

  int checks = 0;
  int failures = 0;
  int done_count = 0;

  k12a_alu_seq dut (
    .clock(clock), .reset_n(reset_n), .start(start), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .busy(busy), .done(done), .err(err),
    .result(result), .alu_load(alu_load), .alu_operand_sel(alu_operand_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_inst(alu_inst), .data_bus(data_bus)
  );

  always #5 clock = ~clock;

  // External ALU: op 6 = arithmetic shift right by one, op 4 = add.
  always_comb begin
    case (alu_inst[10:8])
      3'd6:    data_bus = {alu_a[7], alu_a[7:1]};
      3'd4:    data_bus = alu_a + alu_b;
      default: data_bus = 8'h00;
    endcase
  end

  always @(negedge clock) begin
    if (done) done_count++;
    checks++;
    if ((err && !done) || alu_operand_sel !== ALU_OPERAND_SEL_B || (alu_inst & 16'hF8FF) !== 16'h0000) begin
      failures++;
      $display("FAIL static_outputs err=%0b done=%0b sel=%0d inst=%h required err only with done, sel=1, inst bits outside [10:8]=0",
               err, done, alu_operand_sel, alu_inst);
    end
  end

  function automatic void model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                                output int lat, output logic [7:0] r, output logic e, output logic ld);
    logic signed [7:0] sa;
    logic [15:0]       p;
    int                n;
    n  = int'(b[2:0]);
    sa = a;
    p  = a * b;
    e  = 1'b0;
    case (op)
      2'b00: begin r = sa >>> n; lat = (n == 0) ? 1 : n; ld = (n != 0); end
      2'b10: begin r = a << n;   lat = (n == 0) ? 1 : n; ld = (n != 0); end
`ifdef K12A_ALU_SEQ_MUL_EN
      2'b01: begin r = p[7:0];   lat = 16; ld = 1'b1; end
`endif
      default: begin r = 8'h00; lat = 1; e = 1'b1; ld = 1'b0; end
    endcase
  endfunction

  task automatic run_cmd(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                         output int lat, output logic [7:0] res, output logic e, output logic load_seen,
                         output logic busy0, output logic post_done, output logic post_busy,
                         output logic [7:0] post_res);
    cmd_op = op; cmd_a = a; cmd_b = b; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    busy0 = busy;
    load_seen = alu_load;
    lat = -1; res = 8'h00; e = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clock); #1;
      if (done) begin lat = k; res = result; e = err; break; end
      load_seen |= alu_load;
    end
    @(posedge clock); #1;
    post_done = done; post_busy = busy; post_res = result;
  endtask

  task automatic check_cmd(input string name, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    int lat, elat;
    logic [7:0] res, eres, pres;
    logic e, ee, ld, eld, b0, pd, pb;
    model(op, a, b, elat, eres, ee, eld);
    run_cmd(op, a, b, lat, res, e, ld, b0, pd, pb, pres);
    checks += 6;
    if (lat != elat) begin failures++; $display("FAIL %s_latency op=%0d a=%h b=%h got=%0d exp=%0d", name, op, a, b, lat, elat); end
    if (res !== eres || pres !== eres) begin failures++; $display("FAIL %s_result op=%0d a=%h b=%h got=%h held=%h exp=%h", name, op, a, b, res, pres, eres); end
    if (e !== ee) begin failures++; $display("FAIL %s_err op=%0d got=%0b exp=%0b", name, op, e, ee); end
    if (ld !== eld) begin failures++; $display("FAIL %s_alu_load op=%0d b=%h got=%0b exp=%0b", name, op, b, ld, eld); end
    if (b0 !== 1'b1) begin failures++; $display("FAIL %s_busy_at_accept got=%0b exp=1", name, b0); end
    if (pd !== 1'b0 || pb !== 1'b0) begin failures++; $display("FAIL %s_after_done done=%0b busy=%0b exp 0 0", name, pd, pb); end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if ({busy, done, err, result, alu_load, alu_a, alu_b, alu_inst} !== 44'h0) begin
      failures++;
      $display("FAIL reset_outputs busy=%0b done=%0b err=%0b result=%h load=%0b a=%h b=%h inst=%h exp all 0",
               busy, done, err, result, alu_load, alu_a, alu_b, alu_inst);
    end
    reset_n = 1'b1;
    check_cmd("first_after_reset", 2'b00, 8'h90, 8'h03);
  endtask

  task automatic test_directed;
    check_cmd("asr_n3", 2'b00, 8'h90, 8'h03);
    check_cmd("asr_n0", 2'b00, 8'h55, 8'h00);
    check_cmd("lsl_n2", 2'b10, 8'h81, 8'h0A);
    check_cmd("lsl_n7", 2'b10, 8'hFF, 8'hFF);
    check_cmd("mul_0d_0b", 2'b01, 8'h0D, 8'h0B);
    check_cmd("mul_ff_ff", 2'b01, 8'hFF, 8'hFF);
    check_cmd("reserved", 2'b11, 8'hA5, 8'h5A);
    // Hand-computed spec values, independent of the model.
    checks += 2;
    begin
      int l; logic [7:0] r, pr; logic e, ld, b0, pd, pb;
      run_cmd(2'b00, 8'h90, 8'h03, l, r, e, ld, b0, pd, pb, pr);
      if (l != 3 || r !== 8'hF2 || e !== 1'b0) begin failures++; $display("FAIL asr_const lat=%0d res=%h err=%0b exp 3 f2 0", l, r, e); end
      run_cmd(2'b10, 8'h81, 8'h0A, l, r, e, ld, b0, pd, pb, pr);
      if (l != 2 || r !== 8'h04) begin failures++; $display("FAIL lsl_const lat=%0d res=%h exp 2 04", l, r); end
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++)
      check_cmd("random", 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
  endtask

  task automatic test_back_to_back;
    int elat, idx[$];
    logic [7:0] eres;
    logic ee, eld;
`ifdef K12A_ALU_SEQ_MUL_EN
    cmd_op = 2'b01; cmd_a = 8'h0D; cmd_b = 8'h0B;
`else
    cmd_op = 2'b00; cmd_a = 8'hC4; cmd_b = 8'h06;
`endif
    model(cmd_op, cmd_a, cmd_b, elat, eres, ee, eld);
    start = 1'b1;
    for (int cyc = 0; cyc <= 3 * (elat + 2); cyc++) begin
      @(posedge clock); #1;
      if (done) begin
        idx.push_back(cyc);
        checks++;
        if (result !== eres) begin failures++; $display("FAIL b2b_result got=%h exp=%h", result, eres); end
      end
    end
    start = 1'b0;
    checks++;
    if (idx.size() != 3) begin
      failures++;
      $display("FAIL b2b_done_count got=%0d exp=3", idx.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (idx[i] != elat + i * (elat + 2)) begin failures++; $display("FAIL b2b_done_cycle n=%0d got=%0d exp=%0d", i, idx[i], elat + i * (elat + 2)); end
      end
    end
    repeat (elat + 3) @(posedge clock);
    #1;
  endtask

  task automatic test_reset_mid;
    int snap;
    repeat (2) @(posedge clock);
    #1;
`ifdef K12A_ALU_SEQ_MUL_EN
    cmd_op = 2'b01; cmd_a = 8'h37; cmd_b = 8'h29;
`else
    cmd_op = 2'b00; cmd_a = 8'h80; cmd_b = 8'h07;
`endif
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    snap = done_count;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy_before_reset got=%0b exp=1", busy); end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, err, result, alu_load, alu_a, alu_b, alu_inst} !== 44'h0) begin
      failures++;
      $display("FAIL mid_reset_outputs busy=%0b done=%0b err=%0b result=%h load=%0b a=%h b=%h inst=%h exp all 0",
               busy, done, err, result, alu_load, alu_a, alu_b, alu_inst);
    end
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;
    repeat (20) @(posedge clock);
    #1;
    checks++;
    if (done_count != snap) begin failures++; $display("FAIL mid_reset_no_done got=%0d exp=%0d", done_count, snap); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    check_cmd("after_mid_reset", 2'b10, 8'h13, 8'h03);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
